// File: rtl/cache_pkg.sv
// Shared widths, address field layout and refill FSM states for the cache refill controller.
package cache_pkg;

    localparam int ADDR_W          = 32;
    localparam int WORD_W          = 32;
    localparam int TAG_W           = 25;
    localparam int OFFSET_W        = 6;
    localparam int BLOCK_W         = 512;
    localparam int WORDS_PER_BLOCK = 16;
    localparam int BEAT_W          = $clog2(WORDS_PER_BLOCK);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_FILL  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } refill_state_e;

endpackage

// File: rtl/cache_refill_ctrl_block_assembler.sv
// Collects refill words into a 512-bit block; beat 0 lands in the lowest word.
module block_assembler
    import cache_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               clear_i,
    input  logic               beat_valid_i,
    input  logic [WORD_W-1:0]  beat_data_i,
    output logic               last_beat_o,
    output logic [BLOCK_W-1:0] block_o
);

    logic [BEAT_W-1:0]  beat_q, beat_d;
    logic [BLOCK_W-1:0] block_q, block_d;

    // Insert the incoming word at the current beat position and advance the counter.
    always_comb begin
        // NOTE: defaults first so every path assigns both signals and no latch is inferred.
        beat_d  = beat_q;
        block_d = block_q;
        if (clear_i) begin
            beat_d = '0;
        end else if (beat_valid_i) begin
            block_d[WORD_W*beat_q +: WORD_W] = beat_data_i;
            beat_d = beat_q + 1'b1;
        end
    end

    // Beat counter and block register; the block keeps its contents between refills.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the wide block register is reset on purpose: the cache must see all-zero data while reset is held.
            beat_q  <= '0;
            block_q <= '0;
        end else begin
            // NOTE: non-blocking so every register updates from the values sampled before the edge.
            beat_q  <= beat_d;
            block_q <= block_d;
        end
    end

    assign last_beat_o = (beat_q == BEAT_W'(WORDS_PER_BLOCK - 1));
    assign block_o     = block_q;

endmodule

// File: rtl/cache_refill_ctrl.sv
// Cache miss refill controller: requests a block from memory, assembles 16 beats,
// writes the block into the cache, and aborts with memErr if memory goes quiet too long.
module cache_refill_ctrl
    import cache_pkg::*;
#(
    parameter int TIMEOUT = 1023
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  cpuAddress,
    input  logic               cpuRead,
    input  logic               cacheHit,
    output logic               memReq,
    output logic [ADDR_W-1:0]  memAddr,
    input  logic               memAck,
    input  logic [WORD_W-1:0]  memData,
    input  logic               memValid,
    output logic [BLOCK_W-1:0] blockData,
    output logic [TAG_W-1:0]   tag,
    output logic               valid,
    output logic               DMWrite,
    output logic               stall,
    output logic               refillDone,
    output logic               memErr
);

    localparam int TO_W = $clog2(TIMEOUT + 1);

    refill_state_e             state_q, state_d;
    logic [ADDR_W-1:OFFSET_W]  addr_q, addr_d;
    logic [TO_W-1:0]           to_q, to_d;

    logic miss;
    logic beat_fire;
    logic fill_start;
    logic last_beat;
    logic timeout_hit;

    // The byte offset within the block never matters for a whole-block fetch.
    logic unused_offset;
    assign unused_offset = ^cpuAddress[OFFSET_W-1:0];

    assign miss       = cpuRead && !cacheHit;
    assign fill_start = (state_q == ST_REQ) && memAck;
    // memValid in the acknowledge cycle is still REQ, so it is never taken as a beat.
    assign beat_fire  = (state_q == ST_FILL) && memValid;

    // An idle cycle that would bring the idle count up to TIMEOUT aborts the refill.
    always_comb begin
        timeout_hit = 1'b0;
        if (to_q == TO_W'(TIMEOUT - 1)) begin
            timeout_hit = ((state_q == ST_REQ)  && !memAck) ||
                          ((state_q == ST_FILL) && !memValid);
        end
    end

    block_assembler u_block_assembler (
        .clk          (clk),
        .reset        (reset),
        .clear_i      (fill_start),
        .beat_valid_i (beat_fire),
        .beat_data_i  (memData),
        .last_beat_o  (last_beat),
        .block_o      (blockData)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: miss -> request -> fill 16 beats -> write -> done, timeout back to idle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (miss) state_d = ST_REQ;
            ST_REQ: begin
                if (memAck)           state_d = ST_FILL;
                else if (timeout_hit) state_d = ST_IDLE;
            end
            ST_FILL: begin
                if (beat_fire && last_beat) state_d = ST_WRITE;
                else if (timeout_hit)       state_d = ST_IDLE;
            end
            ST_WRITE: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output decode; everything except memErr depends on the registered state only.
    always_comb begin
        memReq     = (state_q == ST_REQ);
        stall      = (state_q != ST_IDLE);
        DMWrite    = (state_q == ST_WRITE);
        valid      = (state_q == ST_WRITE);
        tag        = (state_q == ST_WRITE) ? addr_q[ADDR_W-1 -: TAG_W] : '0;
        refillDone = (state_q == ST_DONE);
        memErr     = timeout_hit;
    end

    assign memAddr = {addr_q, {OFFSET_W{1'b0}}};

    // Address latch and idle-cycle counter; the acknowledge also restarts the idle count
    // so the wait for the first beat gets the full TIMEOUT budget.
    always_comb begin
        addr_d = addr_q;
        to_d   = to_q;
        unique case (state_q)
            ST_IDLE: begin
                to_d = '0;
                if (miss) addr_d = cpuAddress[ADDR_W-1:OFFSET_W];
            end
            ST_REQ:  to_d = memAck   ? '0 : to_q + 1'b1;
            ST_FILL: to_d = memValid ? '0 : to_q + 1'b1;
            default: to_d = '0;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q <= '0;
            to_q   <= '0;
        end else begin
            addr_q <= addr_d;
            to_q   <= to_d;
        end
    end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Randomized scoreboard bench for cache_refill_ctrl: the driver derives each refill's
// outcome (write or timeout, cycle, tag, block) from the transfer it issues; a monitor
// compares those expectations against the DUT strobes.
module tb_cache_refill_ctrl;
    import cache_pkg::*;

    localparam int TO = 8;

    logic               clk = 1'b0;
    logic               reset;
    logic [31:0]        cpuAddress;
    logic               cpuRead;
    logic               cacheHit;
    logic               memReq;
    logic [31:0]        memAddr;
    logic               memAck;
    logic [31:0]        memData;
    logic               memValid;
    logic [511:0]       blockData;
    logic [24:0]        tag;
    logic               valid;
    logic               DMWrite;
    logic               stall;
    logic               refillDone;
    logic               memErr;

    cache_refill_ctrl #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .cpuAddress (cpuAddress),
        .cpuRead    (cpuRead),
        .cacheHit   (cacheHit),
        .memReq     (memReq),
        .memAddr    (memAddr),
        .memAck     (memAck),
        .memData    (memData),
        .memValid   (memValid),
        .blockData  (blockData),
        .tag        (tag),
        .valid      (valid),
        .DMWrite    (DMWrite),
        .stall      (stall),
        .refillDone (refillDone),
        .memErr     (memErr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit           is_err;
        int           cyc;
        logic [24:0]  tag;
        logic [511:0] blk;
    } evt_t;

    evt_t        evt_q[$];
    logic [31:0] addr_q[$];
    logic [511:0] last_blk = '0;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Values that the DUT must ignore outside IDLE.
    task automatic junk_ctrl();
        cpuRead    = 1'($urandom);
        cacheHit   = 1'($urandom);
        cpuAddress = $urandom;
    endtask

    // IDLE cycles without a miss; memory-side noise must be ignored.
    task automatic idle(input int n);
        repeat (n) begin
            step();
            cpuRead    = 1'($urandom);
            cacheHit   = 1'b1;
            cpuAddress = $urandom;
            memAck     = 1'($urandom);
            memValid   = 1'($urandom);
            memData    = $urandom;
        end
    endtask

    task automatic push_err();
        evt_t e;
        e.is_err = 1'b1;
        e.cyc    = cyc;
        e.tag    = '0;
        e.blk    = '0;
        evt_q.push_back(e);
    endtask

    // One miss. ack_dly < 0: never acknowledge. gap_mode 0: back-to-back, 1: alternating,
    // 2: random 0..2 idle cycles. stall_beat: TO idle cycles before that beat.
    // rst_beat: assert reset right after that beat is captured.
    task automatic run_miss(input logic [31:0] a, input int ack_dly, input int gap_mode,
                            input int stall_beat, input int rst_beat, input bit fixed);
        logic [511:0] blk;
        int n;
        int g;
        evt_t e;
        blk = '0;
        step();
        cpuRead = 1'b1; cacheHit = 1'b0; cpuAddress = a;
        memAck = 1'b1; memValid = 1'b1; memData = $urandom;
        addr_q.push_back({a[31:6], 6'b0});
        n = 0;
        for (int i = 0; (ack_dly < 0) || (i < ack_dly); i++) begin
            step();
            junk_ctrl();
            memAck = 1'b0; memValid = 1'($urandom); memData = $urandom;
            n++;
            if (n == TO) begin
                push_err();
                return;
            end
        end
        step();
        junk_ctrl();
        memAck = 1'b1; memValid = 1'b1; memData = 32'hDEAD_BEEF;
        n = 0;
        for (int k = 0; k < 16; k++) begin
            g = (gap_mode == 0) ? 0 : (gap_mode == 1) ? ((k == 0) ? 0 : 1) : int'($urandom_range(2, 0));
            if (k == stall_beat) g = TO;
            for (int j = 0; j < g; j++) begin
                step();
                junk_ctrl();
                memAck = 1'($urandom); memValid = 1'b0; memData = $urandom;
                n++;
                if (n == TO) begin
                    push_err();
                    return;
                end
            end
            step();
            junk_ctrl();
            memAck = 1'($urandom); memValid = 1'b1;
            memData = fixed ? 32'(k) : $urandom;
            blk[32*k +: 32] = memData;
            n = 0;
            if (k == 15) begin
                e.is_err = 1'b0;
                e.cyc    = cyc + 1;
                e.tag    = a[31:7];
                e.blk    = blk;
                evt_q.push_back(e);
            end
            if (k == rst_beat) begin
                step();
                reset = 1'b1;
                cpuRead = 1'b0; memValid = 1'b1; memAck = 1'b1;
                @(negedge clk);
                check("reset_mid_fill_ctrl", {memReq, memAddr, tag, valid, DMWrite, stall, refillDone, memErr}, '0);
                check("reset_mid_fill_block", blockData, '0);
                step();
                reset = 1'b0;
                cpuRead = 1'b0; cacheHit = 1'b0; memValid = 1'b0; memAck = 1'b0;
                return;
            end
        end
        // WRITE and DONE cycles: memory and CPU noise must be ignored.
        step(); junk_ctrl(); memAck = 1'b1; memValid = 1'b1; memData = $urandom;
        step(); junk_ctrl(); memAck = 1'b1; memValid = 1'b1; memData = $urandom;
        last_blk = blk;
    endtask

    // Monitor: pops expectations whenever the DUT presents a request, write or error.
    logic prev_req = 1'b0;
    logic prev_wr  = 1'b0;
    logic prev_err = 1'b0;
    evt_t mon_e;
    always @(negedge clk) begin
        if (reset) begin
            prev_req = 1'b0;
            prev_wr  = 1'b0;
            prev_err = 1'b0;
        end else begin
            if (memReq && !prev_req) begin
                if (addr_q.size() == 0) check("unexpected_memReq", memReq, 1'b0);
                else                    check("memAddr", memAddr, addr_q.pop_front());
            end
            if (DMWrite || memErr) begin
                if (evt_q.size() == 0) begin
                    check("unexpected_DMWrite_memErr", {DMWrite, memErr}, 2'b00);
                end else begin
                    mon_e = evt_q.pop_front();
                    check("event_kind_memErr", memErr, mon_e.is_err);
                    check("event_kind_DMWrite", DMWrite, !mon_e.is_err);
                    check("event_cycle", cyc, mon_e.cyc);
                    if (!mon_e.is_err) begin
                        check("tag", tag, mon_e.tag);
                        check("valid", valid, 1'b1);
                        check("stall_during_write", stall, 1'b1);
                        check("blockData", blockData, mon_e.blk);
                    end
                end
            end
            if (prev_wr)             check("refillDone_after_write", refillDone, 1'b1);
            else if (refillDone)     check("refillDone_spurious", refillDone, 1'b0);
            if (prev_err)            check("idle_after_memErr", {memReq, stall, DMWrite}, 3'b000);
            prev_req = memReq;
            prev_wr  = DMWrite;
            prev_err = memErr;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        cpuAddress = '0; cpuRead = 1'b0; cacheHit = 1'b0;
        memAck = 1'b0; memData = '0; memValid = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_ctrl", {memReq, memAddr, tag, valid, DMWrite, stall, refillDone, memErr}, '0);
        check("reset_block", blockData, '0);
        step();
        reset = 1'b0;
        idle(3);

        // Directed miss with incrementing data.
        run_miss(32'h0000_1F48, 3, 0, -1, -1, 1'b1);
        idle(3);
        @(negedge clk);
        check("block_hold_after_done", blockData, last_blk);

        // Hits never start a refill.
        step();
        cpuRead = 1'b1; cacheHit = 1'b1; cpuAddress = $urandom; memValid = 1'b1;
        repeat (3) begin
            step();
            cpuAddress = $urandom;
        end
        @(negedge clk);
        check("hit_no_stall_req_write", {stall, memReq, DMWrite}, 3'b000);

        // Alternating beats, then a request that is never acknowledged.
        run_miss($urandom, 1, 1, -1, -1, 1'b0);
        idle(2);
        run_miss($urandom, -1, 0, -1, -1, 1'b0);
        idle(2);

        // Reset after beat 7, then a fresh refill must start at beat 0.
        run_miss($urandom, 2, 0, -1, 7, 1'b0);
        @(negedge clk);
        check("idle_after_reset", {stall, memReq}, 2'b00);
        idle(2);
        run_miss($urandom, 0, 0, -1, -1, 1'b1);
        idle(2);

        // Memory stops mid-fill.
        run_miss($urandom, 1, 2, 5, -1, 1'b0);
        idle(2);

        // Random traffic.
        for (int t = 0; t < 20; t++) begin
            if ($urandom_range(3, 0) == 0) idle(2);
            run_miss($urandom, int'($urandom_range(3, 0)), 2, -1, -1, 1'b0);
            idle(int'($urandom_range(2, 0)));
        end
        idle(5);
        @(negedge clk);
        check("addr_queue_drained", 32'(addr_q.size()), 32'd0);
        check("event_queue_drained", 32'(evt_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
